// File: rtl/alu_writeback.sv
// alu_writeback: captures an ALU result on a ready rising edge and retires it as a
// register-file write (with ack timeout), a branch redirect, or an error completion.
//   soc_clk, reset (async, active-low)
//   ALU_ready/ALU_out/ALU_con_met/ALU_err, Instruction_to_ALU, wb_rd/wb_pc/wb_imm : capture inputs
//   rf_wr_ack -> rf_wr_en/rf_wr_addr/rf_wr_data : register write handshake
//   pc_redirect/pc_target : branch outcome, valid with wb_done
//   wb_busy/wb_done/wb_err/wb_drop : status
module alu_writeback #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        ALU_ready,
    input  logic [31:0] ALU_out,
    input  logic        ALU_con_met,
    input  logic        ALU_err,
    input  logic [4:0]  Instruction_to_ALU,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_imm,
    input  logic        rf_wr_ack,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        wb_busy,
    output logic        wb_done,
    output logic        wb_err,
    output logic        wb_drop
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, WRITE, BRANCH, DONE} state_t;
    state_t state, state_d;
    logic ready_q, rise, capture, bad, is_br, con_q;
    logic err_q, err_d, redir_q, redir_d, drop_q;
    logic [CW-1:0] cnt, cnt_d;
    logic [4:0] rd_q;
    logic [31:0] data_q, pc_q, imm_q, tgt_q, tgt_d, tgt;
    assign rise = ALU_ready & ~ready_q;
    assign capture = rise && state == IDLE;
    assign bad = ALU_err || Instruction_to_ALU >= 5'd16;
    assign is_br = Instruction_to_ALU <= 5'd5;
    assign tgt = con_q ? pc_q + imm_q : pc_q + 32'd4;
    // err/redirect flags are decided on the way into DONE and only exposed while there
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        err_d = err_q;
        redir_d = redir_q;
        tgt_d = tgt_q;
        case (state)
            IDLE: if (capture) begin
                err_d = bad;
                redir_d = 1'b0;
                cnt_d = CW'(1);
                state_d = bad ? DONE : is_br ? BRANCH : wb_rd != 5'd0 ? WRITE : DONE;
            end
            WRITE: if (rf_wr_ack) state_d = DONE;
            else if (cnt == CW'(ACK_TIMEOUT)) begin
                state_d = DONE;
                err_d = 1'b1;
            end else cnt_d = cnt + CW'(1);
            BRANCH: begin
                tgt_d = tgt;
                err_d = con_q && tgt[1:0] != 2'b00;
                redir_d = con_q && tgt[1:0] == 2'b00;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ready_q <= 1'b0;
            cnt <= '0;
            err_q <= 1'b0;
            redir_q <= 1'b0;
            tgt_q <= '0;
            drop_q <= 1'b0;
            rd_q <= '0;
            data_q <= '0;
            pc_q <= '0;
            imm_q <= '0;
            con_q <= 1'b0;
        end else begin
            state <= state_d;
            ready_q <= ALU_ready;
            cnt <= cnt_d;
            err_q <= err_d;
            redir_q <= redir_d;
            tgt_q <= tgt_d;
            drop_q <= drop_q | (rise && state != IDLE);
            if (capture) begin
                rd_q <= wb_rd;
                data_q <= (Instruction_to_ALU == 5'd9 || Instruction_to_ALU == 5'd10) ? {31'b0, ALU_con_met} : ALU_out;
                pc_q <= wb_pc;
                imm_q <= wb_imm;
                con_q <= ALU_con_met;
            end
        end
    end
    assign rf_wr_en = state == WRITE;
    assign rf_wr_addr = rf_wr_en ? rd_q : 5'd0;
    assign rf_wr_data = rf_wr_en ? data_q : 32'd0;
    assign wb_busy = state != IDLE;
    assign wb_done = state == DONE;
    assign wb_err = wb_done & err_q;
    assign pc_redirect = wb_done & redir_q;
    assign pc_target = tgt_q;
    assign wb_drop = drop_q;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: randomized and directed checks of alu_writeback against a transaction-level model.
module tb_alu_writeback;
    localparam int TO = 8;
    logic soc_clk = 1'b0;
    logic reset = 1'b1;
    logic ALU_ready, ALU_con_met, ALU_err, rf_wr_ack;
    logic [31:0] ALU_out, wb_pc, wb_imm;
    logic [4:0] Instruction_to_ALU, wb_rd;
    logic rf_wr_en, pc_redirect, wb_busy, wb_done, wb_err, wb_drop;
    logic [4:0] rf_wr_addr;
    logic [31:0] rf_wr_data, pc_target;
    int checks = 0;
    int passed = 0;

    typedef struct packed {
        int          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stable;
        int          done_c;
        int          dones;
        int          errs;
        int          redirs;
        logic        busy_after;
    } res_t;

    alu_writeback #(.ACK_TIMEOUT(TO)) dut (
        .soc_clk(soc_clk), .reset(reset), .ALU_ready(ALU_ready), .ALU_out(ALU_out),
        .ALU_con_met(ALU_con_met), .ALU_err(ALU_err), .Instruction_to_ALU(Instruction_to_ALU),
        .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_imm(wb_imm), .rf_wr_ack(rf_wr_ack),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .wb_busy(wb_busy),
        .wb_done(wb_done), .wb_err(wb_err), .wb_drop(wb_drop)
    );

    always #5 soc_clk = ~soc_clk;

    function automatic string fmt(input res_t r);
        return $sformatf("wr=%0d addr=%0d data=%h stable=%0d done_c=%0d dones=%0d errs=%0d redirs=%0d busy_after=%0d",
                         r.wr, r.addr, r.data, r.stable, r.done_c, r.dones, r.errs, r.redirs, r.busy_after);
    endfunction

    // Expected outcome of one transaction; d is the write cycle (1-based) in which ack is offered, 0 = never.
    function automatic res_t model(input logic [4:0] op, input logic [31:0] out, input logic con, aerr,
                                   input logic [4:0] rd, input logic [31:0] pc, imm, input int d,
                                   output logic [31:0] tgt, output logic br);
        res_t r;
        r = '0;
        r.stable = 1'b1;
        r.dones = 1;
        tgt = 32'd0;
        br = 1'b0;
        if (aerr || op >= 16) begin
            r.errs = 1;
            r.done_c = 0;
        end else if (op <= 5) begin
            br = 1'b1;
            tgt = con ? pc + imm : pc + 32'd4;
            r.done_c = 1;
            if (con && tgt[1:0] != 2'b00) r.errs = 1;
            else if (con) r.redirs = 1;
        end else if (rd == 0) begin
            r.done_c = 0;
        end else begin
            r.wr = (d >= 1 && d <= TO) ? d : TO;
            r.errs = (d >= 1 && d <= TO) ? 0 : 1;
            r.addr = rd;
            r.data = (op == 9 || op == 10) ? {31'b0, con} : out;
            r.done_c = r.wr;
        end
        return r;
    endfunction

    // Drives one capture and records what the DUT does; no judgement here.
    task automatic observe(input logic [4:0] op, input logic [31:0] out, input logic con, aerr,
                           input logic [4:0] rd, input logic [31:0] pc, imm, input int d, repulse,
                           output res_t r, output logic [31:0] tgt);
        bit first = 1'b1;
        @(negedge soc_clk);
        Instruction_to_ALU = op; ALU_out = out; ALU_con_met = con; ALU_err = aerr;
        wb_rd = rd; wb_pc = pc; wb_imm = imm; rf_wr_ack = 1'b0; ALU_ready = 1'b1;
        r = '0;
        r.stable = 1'b1;
        r.done_c = -1;
        tgt = 32'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge soc_clk);
            if (rf_wr_en) begin
                r.wr++;
                if (first) begin
                    r.addr = rf_wr_addr;
                    r.data = rf_wr_data;
                    first = 1'b0;
                end else if (rf_wr_addr !== r.addr || rf_wr_data !== r.data) r.stable = 1'b0;
            end
            if (wb_done) begin
                r.dones++;
                if (r.done_c < 0) begin
                    r.done_c = c;
                    tgt = pc_target;
                end
            end
            if (wb_err) r.errs++;
            if (pc_redirect) r.redirs++;
            if (r.done_c >= 0 && c > r.done_c && wb_busy) r.busy_after = 1'b1;
            rf_wr_ack = d > 0 && c == d - 1;
            ALU_ready = repulse > 0 && c >= repulse;
            if (c == 0) begin
                ALU_out = $urandom; wb_rd = 5'($urandom); wb_pc = $urandom; wb_imm = $urandom;
                ALU_con_met = 1'($urandom); Instruction_to_ALU = 5'($urandom); ALU_err = 1'($urandom);
            end
            if (r.done_c >= 0 && c >= r.done_c + 3) break;
        end
        rf_wr_ack = 1'b0;
        ALU_ready = 1'b0;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] out, input logic con, aerr,
                       input logic [4:0] rd, input logic [31:0] pc, imm, input int d, repulse,
                       output res_t o, e, output logic [31:0] ot, et, output logic br);
        observe(op, out, con, aerr, rd, pc, imm, d, repulse, o, ot);
        e = model(op, out, con, aerr, rd, pc, imm, d, et, br);
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rf_wr_en, rf_wr_addr, rf_wr_data, pc_redirect, pc_target, wb_busy, wb_done, wb_err, wb_drop} !== '0)
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h redir=%b tgt=%h busy=%b done=%b err=%b drop=%b, expected all 0",
                     rf_wr_en, rf_wr_addr, rf_wr_data, pc_redirect, pc_target, wb_busy, wb_done, wb_err, wb_drop);
        else passed++;
        repeat (3) @(negedge soc_clk);
        reset = 1'b1;
        @(negedge soc_clk);
        checks++;
        if ({wb_busy, wb_done, rf_wr_en} !== 3'b000)
            $display("FAIL reset_release_idle: got busy=%b done=%b en=%b, expected 000", wb_busy, wb_done, rf_wr_en);
        else passed++;
    endtask

    task automatic test_write;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        run(5'd6, 32'h0000_00FF, 1'b0, 1'b0, 5'd5, 32'h40, 32'h8, 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL write_op6: got %s expected %s", fmt(o), fmt(e)); else passed++;
        checks++;
        if (o.wr != 1 || o.addr !== 5'd5 || o.data !== 32'hFF || o.done_c != 1)
            $display("FAIL write_op6_fixed: got wr=%0d addr=%0d data=%h done_c=%0d, expected 1/5/ff/1", o.wr, o.addr, o.data, o.done_c);
        else passed++;
        run(5'd9, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 2, 0, o, e, ot, et, br);
        checks++;
        if (o.data !== 32'h1 || o !== e) $display("FAIL write_slt: got %s expected %s", fmt(o), fmt(e)); else passed++;
        run(5'd10, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 3, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL write_sltu: got %s expected %s", fmt(o), fmt(e)); else passed++;
        run(5'd7, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL write_rd0: got %s expected %s", fmt(o), fmt(e)); else passed++;
    endtask

    task automatic test_branch;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        run(5'd0, 32'h0, 1'b1, 1'b0, 5'd1, 32'h100, 32'hFFFF_FFF8, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || ot !== 32'h0F8 || o.redirs != 1)
            $display("FAIL branch_taken: got %s tgt=%h expected %s tgt=0f8", fmt(o), ot, fmt(e));
        else passed++;
        run(5'd0, 32'h0, 1'b0, 1'b0, 5'd1, 32'h100, 32'hFFFF_FFF8, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || ot !== 32'h104 || o.redirs != 0)
            $display("FAIL branch_not_taken: got %s tgt=%h expected %s tgt=104", fmt(o), ot, fmt(e));
        else passed++;
        run(5'd3, 32'h0, 1'b1, 1'b0, 5'd1, 32'h100, 32'h6, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || ot !== 32'h106) $display("FAIL branch_misaligned: got %s tgt=%h expected %s tgt=106", fmt(o), ot, fmt(e));
        else passed++;
        run(5'd5, 32'h0, 1'b0, 1'b0, 5'd1, 32'hFFFF_FFFC, 32'h0, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || ot !== 32'h0) $display("FAIL branch_wrap: got %s tgt=%h expected %s tgt=0", fmt(o), ot, fmt(e));
        else passed++;
        run(5'd2, 32'h0, 1'b1, 1'b1, 5'd1, 32'h200, 32'h8, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL branch_alu_err: got %s expected %s", fmt(o), fmt(e)); else passed++;
    endtask

    task automatic test_timeout;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        run(5'd6, 32'hA5A5_0001, 1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 0, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || o.wr != 8 || o.errs != 1) $display("FAIL timeout_never: got %s expected %s", fmt(o), fmt(e)); else passed++;
        run(5'd8, 32'h0000_7777, 1'b0, 1'b0, 5'd9, 32'h0, 32'h0, TO, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || o.errs != 0) $display("FAIL timeout_ack_at_limit: got %s expected %s", fmt(o), fmt(e)); else passed++;
        run(5'd11, 32'h0000_8888, 1'b0, 1'b0, 5'd10, 32'h0, 32'h0, TO + 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL timeout_ack_late: got %s expected %s", fmt(o), fmt(e)); else passed++;
    endtask

    task automatic test_invalid;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        run(5'd17, 32'h1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0, 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || o.wr != 0 || o.errs != 1) $display("FAIL invalid_op17: got %s expected %s", fmt(o), fmt(e)); else passed++;
        run(5'd12, 32'h1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL invalid_alu_err: got %s expected %s", fmt(o), fmt(e)); else passed++;
    endtask

    task automatic test_random;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        logic [4:0] op;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            op = sel < 3 ? 5'($urandom_range(0, 5)) : sel < 8 ? 5'($urandom_range(6, 15)) : 5'($urandom_range(16, 31));
            run(op, $urandom, 1'($urandom), $urandom_range(0, 9) == 0, 5'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 10), 0, o, e, ot, et, br);
            checks++;
            if (o !== e || (br && ot !== et))
                $display("FAIL random_%0d op=%0d: got %s tgt=%h expected %s tgt=%h", i, op, fmt(o), ot, fmt(e), et);
            else passed++;
        end
    endtask

    task automatic test_drop;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        checks++;
        if (wb_drop !== 1'b0) $display("FAIL drop_initial: got %b expected 0", wb_drop); else passed++;
        run(5'd6, 32'h0BAD_F00D, 1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 5, 2, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL drop_write: got %s expected %s", fmt(o), fmt(e)); else passed++;
        checks++;
        if (wb_drop !== 1'b1) $display("FAIL drop_set: got %b expected 1", wb_drop); else passed++;
        run(5'd13, 32'h55, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0, 1, 0, o, e, ot, et, br);
        checks++;
        if (o !== e || wb_drop !== 1'b1) $display("FAIL drop_sticky: got %s drop=%b expected %s drop=1", fmt(o), wb_drop, fmt(e));
        else passed++;
    endtask

    task automatic test_reset_mid_write;
        res_t o, e;
        logic [31:0] ot, et;
        logic br;
        bit clean = 1'b1;
        @(negedge soc_clk);
        Instruction_to_ALU = 5'd6; ALU_out = 32'hCAFE_0000; ALU_err = 1'b0; wb_rd = 5'd7; rf_wr_ack = 1'b0; ALU_ready = 1'b1;
        @(negedge soc_clk);
        ALU_ready = 1'b0;
        @(negedge soc_clk);
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7) $display("FAIL midwrite_active: got en=%b addr=%0d expected 1/7", rf_wr_en, rf_wr_addr);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rf_wr_en, rf_wr_addr, rf_wr_data, pc_redirect, pc_target, wb_busy, wb_done, wb_err, wb_drop} !== '0)
            $display("FAIL midwrite_async: got en=%b addr=%0d data=%h busy=%b drop=%b expected all 0", rf_wr_en, rf_wr_addr, rf_wr_data, wb_busy, wb_drop);
        else passed++;
        @(negedge soc_clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge soc_clk);
            if ({rf_wr_en, rf_wr_addr, rf_wr_data, pc_redirect, pc_target, wb_busy, wb_done, wb_err, wb_drop} !== '0) clean = 1'b0;
        end
        checks++;
        if (!clean) $display("FAIL midwrite_after_release: got nonzero outputs (en=%b busy=%b drop=%b), expected all 0", rf_wr_en, wb_busy, wb_drop);
        else passed++;
        run(5'd14, 32'h0000_0042, 1'b0, 1'b0, 5'd31, 32'h0, 32'h0, 2, 0, o, e, ot, et, br);
        checks++;
        if (o !== e) $display("FAIL midwrite_recover: got %s expected %s", fmt(o), fmt(e)); else passed++;
    endtask

    initial begin
        ALU_ready = 1'b0; ALU_out = '0; ALU_con_met = 1'b0; ALU_err = 1'b0; rf_wr_ack = 1'b0;
        Instruction_to_ALU = '0; wb_rd = '0; wb_pc = '0; wb_imm = '0;
        test_reset;
        test_write;
        test_branch;
        test_timeout;
        test_invalid;
        test_random;
        test_drop;
        test_reset_mid_write;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
